// File: rtl/snes_pkg.sv
// Shared types and default constants for the SNES controller-port serializer.
package snes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int   DEF_NUM_PORTS   = 2;
  localparam int   DEF_NUM_BUTTONS = 12;
  localparam int   DEF_FRAME_BITS  = 16;
  localparam logic DEF_FILL_BIT    = 1'b1;
  localparam logic DEF_ACTIVE_LOW  = 1'b1;
  localparam int   DEF_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pin, plus rise/fall pulse detection.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] are the synchroniser; [2] holds the previous synchronised level.
  logic [2:0] sync_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, which is what makes a shift chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], din_i};
  end

  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/snes_pad_serializer.sv
// SNES controller emulation: latches button state and shifts it out on the
// console's shift clock, one serial line per controller port.
module snes_pad_serializer
  import snes_pkg::*;
#(
  parameter int   NUM_PORTS   = DEF_NUM_PORTS,
  parameter int   NUM_BUTTONS = DEF_NUM_BUTTONS,
  parameter int   FRAME_BITS  = DEF_FRAME_BITS,
  parameter logic FILL_BIT    = DEF_FILL_BIT,
  parameter logic ACTIVE_LOW  = DEF_ACTIVE_LOW,
  parameter int   TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             latch_in,
  input  logic                             sclk_in,
  input  logic [NUM_PORTS*NUM_BUTTONS-1:0] buttons,
  input  logic                             enable,
  input  logic                             clr_err,
  output logic [NUM_PORTS-1:0]             data_out,
  output logic                             busy,
  output logic                             frame_done,
  output logic [15:0]                      frame_count,
  output logic                             timeout_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  // Line levels for a whole frame: encoded button bits, then the fill level.
  function automatic logic [FRAME_BITS-1:0] port_frame(input logic [NUM_BUTTONS-1:0] btn);
    logic [FRAME_BITS-1:0] f;
    f = {FRAME_BITS{FILL_BIT}};
    f[NUM_BUTTONS-1:0] = btn ^ {NUM_BUTTONS{ACTIVE_LOW}};
    return f;
  endfunction

  localparam logic [FRAME_BITS-1:0] REL_FRAME = port_frame('0);

  logic latch_rise, latch_fall, sclk_rise, sclk_fall;

  sync_edge_det u_latch_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (latch_in),
    .rise_o (latch_rise),
    .fall_o (latch_fall)
  );

  sync_edge_det u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (sclk_in),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [TMR_W-1:0]      tmr_q;
  logic [FRAME_BITS-1:0] sr_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]  data_q;
  logic                  done_q;
  logic [15:0]           count_q;
  logic                  err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '1;
      done_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
      // NOTE: the frame registers are plain flops, not a RAM, so they are
      // reset like any other state to the all-released pattern.
      for (int p = 0; p < NUM_PORTS; p++) sr_q[p] <= REL_FRAME;
    end else begin
      done_q <= 1'b0;
      if (clr_err) err_q <= 1'b0;
      if (!enable) begin
        state_q <= ST_IDLE;
        data_q  <= '1;
        tmr_q   <= '0;
      end else if (latch_rise) begin
        // A new latch always restarts the frame, whatever was in flight.
        state_q <= ST_LOAD;
        cnt_q   <= '0;
        tmr_q   <= '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          sr_q[p]   <= port_frame(buttons[p*NUM_BUTTONS +: NUM_BUTTONS]);
          data_q[p] <= buttons[p*NUM_BUTTONS] ^ ACTIVE_LOW;
        end
      end else begin
        case (state_q)
          ST_IDLE: data_q <= '1;
          ST_LOAD: begin
            if (latch_fall) begin
              state_q <= ST_SHIFT;
              tmr_q   <= '0;
            end
          end
          ST_SHIFT: begin
            if (sclk_rise) begin
              tmr_q <= '0;
              if (cnt_q == LAST_BIT) begin
                state_q <= ST_DONE;
                data_q  <= '0;
                done_q  <= 1'b1;
                count_q <= count_q + 16'd1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                for (int p = 0; p < NUM_PORTS; p++) begin
                  sr_q[p]   <= sr_q[p] >> 1;
                  data_q[p] <= sr_q[p][1];
                end
              end
            end else if (sclk_fall || latch_fall) begin
              tmr_q <= '0;
            end else if (tmr_q == TMO_LAST) begin
              // Written after the clr_err clear so a same-cycle timeout wins.
              state_q <= ST_IDLE;
              data_q  <= '1;
              tmr_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          ST_DONE: data_q  <= '0;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_snes_pad_serializer.sv
// Directed bench for snes_pad_serializer: frame content, restart, timeout,
// latch/sclk priority, enable and reset behaviour.
module tb_snes_pad_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        latch_in;
  logic        sclk_in;
  logic [23:0] buttons;
  logic        enable;
  logic        clr_err;
  logic [1:0]  data_out;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int done_mark;

  // Hand-derived line levels per frame bit for port0=12'h001, port1=12'h800.
  logic [15:0] p0_line;
  logic [15:0] p1_line;

  snes_pad_serializer #(.TIMEOUT_CYC(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .latch_in    (latch_in),
    .sclk_in     (sclk_in),
    .buttons     (buttons),
    .enable      (enable),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) done_seen <= done_seen + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    latch_in = 1'b1;
    tick(4);
    latch_in = 1'b0;
    tick(4);
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_in = 1'b1;
      tick(3);
      sclk_in = 1'b0;
      tick(3);
    end
  endtask

  initial begin
    p0_line  = 16'b1111_1111_1111_1110;
    p1_line  = 16'b1111_0111_1111_1111;
    reset    = 1'b0;
    latch_in = 1'b0;
    sclk_in  = 1'b0;
    enable   = 1'b1;
    clr_err  = 1'b0;
    buttons  = {12'h800, 12'h001};
    tick(3);
    check("rst_data", data_out, 2'b11);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_count", frame_count, 16'd0);
    check("rst_err", timeout_err, 1'b0);
    reset = 1'b1;
    tick(2);

    // Full frame: bit 0 visible in LOAD, bits 1..15 after each rise.
    latch_in = 1'b1;
    tick(3);
    check("load_bit0", data_out, {p1_line[0], p0_line[0]});
    check("load_busy", busy, 1'b1);
    tick(1);
    latch_in = 1'b0;
    tick(4);
    check("shift_bit0", data_out, 2'b10);
    for (int i = 1; i < 16; i++) begin
      sclk_in = 1'b1;
      tick(3);
      check($sformatf("bit%0d", i), data_out, {p1_line[i], p0_line[i]});
      sclk_in = 1'b0;
      tick(3);
    end
    sclk_in = 1'b1;
    tick(3);
    check("done_pulse", frame_done, 1'b1);
    check("done_data", data_out, 2'b00);
    check("done_count", frame_count, 16'd1);
    check("done_busy", busy, 1'b0);
    tick(1);
    check("done_pulse_end", frame_done, 1'b0);
    sclk_in = 1'b0;
    tick(10);
    check("done_hold", data_out, 2'b00);

    // Restart after 5 rises: counter must go back to 0.
    done_mark = done_seen;
    start_frame();
    rises(5);
    latch_in = 1'b1;
    tick(3);
    check("restart_bit0", data_out, 2'b10);
    check("restart_busy", busy, 1'b1);
    tick(1);
    latch_in = 1'b0;
    tick(4);
    rises(10);
    sclk_in = 1'b1;
    tick(3);
    check("restart_bit11", data_out, 2'b01);
    sclk_in = 1'b0;
    tick(3);
    check("restart_nodone", done_seen, done_mark);
    check("restart_err", timeout_err, 1'b0);
    rises(5);
    check("restart_count", frame_count, 16'd2);

    // Timeout: sclk held high after rise 3, nothing else moves.
    start_frame();
    rises(2);
    sclk_in = 1'b1;
    tick(3);
    tick(99);
    check("tmo_busy_before", busy, 1'b1);
    check("tmo_err_before", timeout_err, 1'b0);
    tick(1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_err", timeout_err, 1'b1);
    check("tmo_data", data_out, 2'b11);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("tmo_clr", timeout_err, 1'b0);
    sclk_in = 1'b0;
    tick(3);

    // Coincident latch and sclk rise: latch wins, counter back to 0.
    start_frame();
    rises(3);
    latch_in = 1'b1;
    sclk_in  = 1'b1;
    tick(3);
    check("coinc_bit0", data_out, 2'b10);
    check("coinc_busy", busy, 1'b1);
    tick(1);
    latch_in = 1'b0;
    sclk_in  = 1'b0;
    tick(4);
    rises(10);
    sclk_in = 1'b1;
    tick(3);
    check("coinc_bit11", data_out, 2'b01);
    sclk_in = 1'b0;
    tick(3);
    rises(5);
    check("coinc_count", frame_count, 16'd3);

    // enable=0 mid-shift parks the block.
    start_frame();
    rises(3);
    enable = 1'b0;
    tick(1);
    check("dis_data", data_out, 2'b11);
    check("dis_busy", busy, 1'b0);
    rises(2);
    check("dis_ignore", data_out, 2'b11);
    check("dis_count", frame_count, 16'd3);
    enable = 1'b1;
    tick(3);

    // Leave the error flag set, then reset in the middle of a frame.
    start_frame();
    rises(1);
    tick(105);
    check("tmo2_err", timeout_err, 1'b1);
    done_mark = done_seen;
    start_frame();
    rises(3);
    reset = 1'b0;
    tick(1);
    check("mrst_data", data_out, 2'b11);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", frame_done, 1'b0);
    check("mrst_count", frame_count, 16'd0);
    check("mrst_err", timeout_err, 1'b0);
    reset = 1'b1;
    tick(5);
    check("mrst_nodone", done_seen, done_mark);
    check("mrst_idle", data_out, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
